four_banks_writer: RTL and testbench

Write-side counterpart to the four-bank byte read mux: accepts a byte stream with bank/byte addressing over a valid/ready handshake and packs the bytes into a 32-bit staging word. It commits the word to one of four 32-bit banks as a one-cycle write pulse with per-byte enables. It sits between the byte-wide host path and the four bank storage arrays that the read mux reads back.

---
 rtl/four_banks_pkg.sv | 58 +++++
 rtl/byte_stager.sv | 59 +++++
 rtl/four_banks_writer.sv | 122 ++++++++++++
 tb/tb_four_banks_writer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/four_banks_pkg.sv
// four_banks_pkg: shared definitions for the four-bank byte read mux and
// the four_banks_writer. Provides word/byte geometry, the bank_sel encoding,
// the writer state enum, the write-request payload and small helpers.
package four_banks_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_BANKS = 4;
    localparam int unsigned LANES     = WORD_W / BYTE_W;
    localparam int unsigned SEL_W     = 2;

    // bank_sel encoding
    localparam logic [SEL_W-1:0] BANK01 = 2'b00;
    localparam logic [SEL_W-1:0] BANK02 = 2'b01;
    localparam logic [SEL_W-1:0] BANK03 = 2'b10;
    localparam logic [SEL_W-1:0] BANK04 = 2'b11;

    // Writing this lane closes the word
    localparam logic [SEL_W-1:0] LANE_TOP = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // One write pulse towards the bank arrays
    typedef struct packed {
        logic [NUM_BANKS-1:0] bank_we;
        logic [LANES-1:0]     be;
        logic [WORD_W-1:0]    data;
    } wr_req_t;

    // One-hot write strobe for a bank_sel code
    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_BANKS-1:0] oh;
        oh = '0;
        case (sel)
            BANK01:  oh = 4'b0001;
            BANK02:  oh = 4'b0010;
            BANK03:  oh = 4'b0100;
            BANK04:  oh = 4'b1000;
            default: oh = '0;
        endcase
        return oh;
    endfunction

    // Expand per-byte enables into a bit mask over the word
    function automatic logic [WORD_W-1:0] be_to_mask(input logic [LANES-1:0] be);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            m[i*BYTE_W +: BYTE_W] = {BYTE_W{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/byte_stager.sv
// byte_stager: 32-bit staging word, per-lane fill mask and stage bank.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en           write data into lane this cycle
//   clr             discard the staged word (mask, data, bank)
//   lane, data      target lane and byte for wr_en
//   bank            bank latched when the first byte enters an empty stage
//   stage_bank      registered stage bank
//   next_*_c        stage contents including this cycle's write (combinational)
module byte_stager
    import four_banks_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              clr,
    input  logic [SEL_W-1:0]  lane,
    input  logic [BYTE_W-1:0] data,
    input  logic [SEL_W-1:0]  bank,
    output logic [SEL_W-1:0]  stage_bank,
    output logic [WORD_W-1:0] next_word_c,
    output logic [LANES-1:0]  next_mask_c,
    output logic [SEL_W-1:0]  next_bank_c
);

    logic [WORD_W-1:0] word;
    logic [LANES-1:0]  mask;

    // Merge this cycle's byte; repeated lane writes overwrite, mask unchanged
    always_comb begin
        next_word_c = word;
        next_mask_c = mask;
        next_bank_c = stage_bank;
        if (wr_en) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (lane == SEL_W'(i)) begin
                    next_word_c[i*BYTE_W +: BYTE_W] = data;
                end
            end
            next_mask_c[lane] = 1'b1;
            if (mask == '0) begin
                next_bank_c = bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word       <= '0;
            mask       <= '0;
            stage_bank <= '0;
        end else begin
            word       <= next_word_c;
            mask       <= next_mask_c;
            stage_bank <= next_bank_c;
        end
    end

endmodule

// File: rtl/four_banks_writer.sv
// four_banks_writer: packs a byte stream (bank/lane addressed, valid/ready)
// into a 32-bit stage and commits it to one of four banks as a one-cycle
// write pulse with byte enables.
// Parameters:
//   FLUSH_TIMEOUT   idle cycles in FILL before a partial word is flushed
//                   (2..255, only with FOUR_BANKS_AUTO_FLUSH_EN defined)
// Macros:
//   FOUR_BANKS_AUTO_FLUSH_EN  enables the idle auto-flush counter
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  byte handshake; in_ready drops during COMMIT, reset and
//                   for a bank conflict
//   in_byte         data byte
//   bank_sel        target bank (00..11 -> Bank01..Bank04)
//   byte_sel        byte lane (00 -> [7:0] .. 11 -> [31:24])
//   in_last         commit after this byte
//   wr_data, wr_be  registered write word and byte enables (zero when idle)
//   bank_we         registered one-hot bank write strobe
module four_banks_writer
    import four_banks_pkg::*;
#(
    parameter int unsigned FLUSH_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic [SEL_W-1:0]  bank_sel,
    input  logic [SEL_W-1:0]  byte_sel,
    input  logic              in_last,
    output logic [WORD_W-1:0] wr_data,
    output logic [LANES-1:0]  wr_be,
    output logic [NUM_BANKS-1:0] bank_we
);

    state_e            state;
    wr_req_t           wr_q;
    logic [SEL_W-1:0]  stage_bank;
    logic [WORD_W-1:0] next_word_c;
    logic [LANES-1:0]  next_mask_c;
    logic [SEL_W-1:0]  next_bank_c;
    logic              conflict_c;
    logic              accept_c;
    logic              trigger_c;
    logic              flush_c;
    logic              commit_c;
    logic              stage_clr;

    // A different bank offered against a partial stage forces a flush first
    assign conflict_c = (state == FILL) && in_valid && (bank_sel != stage_bank);
    assign in_ready   = !rst && ((state == IDLE) || ((state == FILL) && !conflict_c));
    assign accept_c   = in_valid && in_ready;
    assign trigger_c  = accept_c && ((byte_sel == LANE_TOP) || in_last);
    assign commit_c   = trigger_c || conflict_c || flush_c;
    assign stage_clr  = (state == COMMIT);

    byte_stager u_stager (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (accept_c),
        .clr         (stage_clr),
        .lane        (byte_sel),
        .data        (in_byte),
        .bank        (bank_sel),
        .stage_bank  (stage_bank),
        .next_word_c (next_word_c),
        .next_mask_c (next_mask_c),
        .next_bank_c (next_bank_c)
    );

`ifdef FOUR_BANKS_AUTO_FLUSH_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(FLUSH_TIMEOUT);

    logic [7:0] idle_cnt;

    // Counts non-accept cycles in FILL, saturating at the timeout
    always_ff @(posedge clk) begin
        if (rst || (state != FILL) || accept_c) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TIMEOUT_CNT) begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end

    assign flush_c = (state == FILL) && !accept_c && (idle_cnt == TIMEOUT_CNT);
`else
    logic [7:0] unused_flush_timeout;

    assign unused_flush_timeout = 8'(FLUSH_TIMEOUT);
    assign flush_c              = 1'b0;
`endif

    // FSM; the write pulse is loaded on the edge that enters COMMIT
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wr_q  <= '0;
        end else begin
            wr_q <= '0;
            case (state)
                IDLE, FILL: begin
                    if (commit_c && (next_mask_c != '0)) begin
                        state        <= COMMIT;
                        wr_q.bank_we <= bank_onehot(next_bank_c);
                        wr_q.be      <= next_mask_c;
                        wr_q.data    <= next_word_c & be_to_mask(next_mask_c);
                    end else if (accept_c) begin
                        state <= FILL;
                    end
                end
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign wr_data = wr_q.data;
    assign wr_be   = wr_q.be;
    assign bank_we = wr_q.bank_we;

endmodule

// File: tb/tb_four_banks_writer.sv
// Scoreboard bench for four_banks_writer: the driver feeds bytes and a
// byte-array model predicts each committed word and its cycle; a negedge
// monitor pops and compares on every write pulse.
module tb_four_banks_writer;
    import four_banks_pkg::*;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic [1:0]  bank_sel;
    logic [1:0]  byte_sel;
    logic        in_last;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [3:0]  bank_we;

    four_banks_writer #(.FLUSH_TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_byte  (in_byte),
        .bank_sel (bank_sel),
        .byte_sel (byte_sel),
        .in_last  (in_last),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .bank_we  (bank_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  we;
        logic [3:0]  be;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   pulses  = 0;
    bit   prev_hi = 1'b0;

    // Reference stage: bytes per lane, fill mask, stage bank
    logic [7:0] m_bytes[4];
    logic [3:0] m_mask = 4'b0;
    logic [1:0] m_bank = 2'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected write of the current model stage, then empty it
    task automatic push_commit(input int exp_cyc);
        exp_t e;
        if (m_mask == 4'b0) return;
        e.we   = 4'b0001 << m_bank;
        e.be   = m_mask;
        e.data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (m_mask[i]) e.data = e.data | (32'(m_bytes[i]) << (8 * i));
        end
        e.cyc = exp_cyc;
        exp_q.push_back(e);
        m_mask = 4'b0;
        for (int i = 0; i < 4; i++) m_bytes[i] = 8'h0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (bank_we != 4'b0) begin
            pulses++;
            check("in_ready_in_commit", 32'(in_ready), 32'd0);
            check("pulse_width", 32'(prev_hi), 32'd0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: bank_we=%b wr_be=%b wr_data=0x%08h required no write (cycle %0d)",
                         bank_we, wr_be, wr_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("bank_we", 32'(bank_we), 32'(e.we));
                check("wr_be", 32'(wr_be), 32'(e.be));
                check("wr_data", wr_data, e.data);
                check("write_cycle", cyc, e.cyc);
            end
            prev_hi = 1'b1;
        end else begin
            check("idle_wr_be", 32'(wr_be), 32'd0);
            check("idle_wr_data", wr_data, 32'd0);
            prev_hi = 1'b0;
        end
    end

    // Offer one byte until accepted; updates the model on acceptance
    task automatic send_byte(input logic [7:0] b, input logic [1:0] bank, input logic [1:0] lane,
                             input logic last, output int stalls, output int acc_cyc);
        logic acc;
        stalls  = 0;
        acc_cyc = 0;
        acc     = 1'b0;
        @(negedge clk);
        // Offering another bank against a partial word flushes it next cycle
        if (m_mask != 4'b0 && bank != m_bank) push_commit(cyc + 1);
        in_valid = 1'b1;
        in_byte  = b;
        bank_sel = bank;
        byte_sel = lane;
        in_last  = last;
        for (int n = 0; n < 20 && !acc; n++) begin
            #4;
            acc     = in_ready;
            acc_cyc = cyc;
            @(posedge clk);
            if (!acc) begin
                stalls++;
                @(negedge clk);
            end
        end
        #1 in_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: byte 0x%0h not accepted, required acceptance within 20 cycles", b);
        end else begin
            if (m_mask == 4'b0) m_bank = bank;
            m_bytes[lane] = b;
            m_mask[lane]  = 1'b1;
            if (lane == 2'b11 || last) push_commit(acc_cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, ac, first_ac, base;
        logic [1:0] rb;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h0;
        bank_sel = 2'b0;
        byte_sel = 2'b0;
        in_last  = 1'b0;
        for (int i = 0; i < 4; i++) m_bytes[i] = 8'h0;

        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        #4 check("in_ready_during_reset", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #4 check("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Full word to bank 10
        send_byte(8'h11, 2'b10, 2'b00, 1'b0, st, ac);
        send_byte(8'h22, 2'b10, 2'b01, 1'b0, st, ac);
        send_byte(8'h33, 2'b10, 2'b10, 1'b0, st, ac);
        send_byte(8'h44, 2'b10, 2'b11, 1'b0, st, ac);
        idle(3);

        // Partial word closed by in_last
        send_byte(8'hAA, 2'b00, 2'b01, 1'b0, st, ac);
        send_byte(8'hBB, 2'b00, 2'b10, 1'b1, st, ac);
        idle(3);

        // Bank conflict
        send_byte(8'h5A, 2'b01, 2'b00, 1'b0, st, ac);
        send_byte(8'hC3, 2'b11, 2'b00, 1'b0, st, ac);
        check("conflict_stall_cycles", st, 2);
        send_byte(8'h99, 2'b11, 2'b11, 1'b0, st, ac);
        idle(3);

        // Lane overwrite
        send_byte(8'h01, 2'b00, 2'b00, 1'b0, st, ac);
        send_byte(8'h02, 2'b00, 2'b00, 1'b0, st, ac);
        send_byte(8'h03, 2'b00, 2'b11, 1'b0, st, ac);
        idle(3);

        // Reset mid-word discards the stage
        send_byte(8'h10, 2'b10, 2'b00, 1'b0, st, ac);
        send_byte(8'h20, 2'b10, 2'b01, 1'b0, st, ac);
        base = pulses;
        @(negedge clk);
        rst = 1'b1;
        #4 check("in_ready_mid_reset", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_mask = 4'b0;
        for (int i = 0; i < 4; i++) m_bytes[i] = 8'h0;
        idle(20);
        check("no_write_after_reset", pulses, base);
        send_byte(8'hA1, 2'b00, 2'b00, 1'b0, st, ac);
        send_byte(8'hA2, 2'b00, 2'b01, 1'b0, st, ac);
        send_byte(8'hA3, 2'b00, 2'b10, 1'b0, st, ac);
        send_byte(8'hA4, 2'b00, 2'b11, 1'b0, st, ac);
        idle(3);

        // Back-to-back full words: 4 bytes per 5 cycles
        for (int w = 0; w < 2; w++) begin
            for (int l = 0; l < 4; l++) begin
                send_byte(8'(8'h60 + 8'(w * 4 + l)), 2'b01, 2'(l), 1'b0, st, ac);
                if (w == 0 && l == 0) first_ac = ac;
                if (w == 1 && l == 0) check("b2b_stall_after_commit", st, 1);
            end
        end
        check("b2b_accept_span", ac - first_ac, 8);
        idle(3);

        // Idle partial word: flushed after the timeout only when configured
        base = pulses;
        send_byte(8'h7E, 2'b11, 2'b10, 1'b0, st, ac);
`ifdef FOUR_BANKS_AUTO_FLUSH_EN
        push_commit(ac + 1 + int'(TIMEOUT) + 1);
        idle(30);
        check("auto_flush_writes", pulses, base + 1);
`else
        idle(40);
        check("no_auto_flush", pulses, base);
        send_byte(8'h11, 2'b11, 2'b00, 1'b1, st, ac);
        idle(3);
`endif

        // Randomized traffic
        rb = 2'($urandom_range(0, 3));
        for (int k = 0; k < 300; k++) begin
            idle(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) rb = 2'($urandom_range(0, 3));
            send_byte(8'($urandom_range(0, 255)), rb, 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 9) == 0), st, ac);
        end
        send_byte(8'hE7, rb, 2'b01, 1'b1, st, ac);
        idle(5);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
